// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   Decode-stage hazard and issue controller. Tracks which architectural
//   registers have an outstanding write and whether the memory and mul/div
//   units are busy. From those it decides whether the decoded instruction may
//   leave decode this cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   issue_valid         decode register holds a valid instruction
//   rs1/rs2, use_rs*    source operands and whether each is read
//   rd, we              destination and write enable
//   fn                  unit select: 0 ALU, 1 branch, 2 mem, 3 muldiv, 4 csr,
//                       5-7 ALU
//   flush               kill the decoded instruction this cycle
//   wb_valid, wb_rd     writeback commit
//   mem_done, md_done   multi-cycle unit completion pulses
//   stall, stallnum     hold decode; reason 00 none, 01 RAW, 10 WAW, 11 struct
//   fire                instruction leaves decode
//   pending             pending-write bitmap (debug view of tracking state)
//   stall_cycles        saturating count of stalled cycles
//
// Handshake: issue_valid is the decode-side valid. The instruction is
// accepted ("fire") in any cycle where issue_valid=1, flush=0 and stall=0.
// stall is only ever asserted while issue_valid=1 and flush=0. Both are
// combinational, so the decode register sees them in the same cycle.
module issue_scoreboard #(
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [4:0]       rd,
  input  logic             we,
  input  logic [2:0]       fn,
  input  logic             flush,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             mem_done,
  input  logic             md_done,
  output logic             stall,
  output logic [1:0]       stallnum,
  output logic             fire,
  output logic [NREGS-1:0] pending,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [2:0] FN_MEM = 3'd2;
  localparam logic [2:0] FN_MD  = 3'd3;
  localparam logic [2:0] FN_CSR = 3'd4;

  logic             mem_busy;
  logic             md_busy;
  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] pend_vec;
  logic [NREGS-1:0] pending_next;
  logic             mem_blk;
  logic             md_blk;
  logic             raw_haz;
  logic             waw_haz;
  logic             struct_haz;
  logic             hazard;

  // A register being written back this cycle is treated as already
  // available (write-first register file), so it is masked out of the
  // hazard view but still present in the stored table until the edge.
  always_comb begin
    wb_mask = '0;
    if (wb_valid && wb_rd != 5'd0) wb_mask[wb_rd] = 1'b1;
  end

  assign pend_vec = pending & ~wb_mask;

  // A done pulse in the same cycle frees the unit for the incoming op.
  assign mem_blk = mem_busy & ~mem_done;
  assign md_blk  = md_busy  & ~md_done;

  assign raw_haz = (use_rs1 & pend_vec[rs1]) | (use_rs2 & pend_vec[rs2]);
  assign waw_haz = we & (rd != 5'd0) & pend_vec[rd];

  // CSR ops serialize: they wait until nothing at all is in flight.
  assign struct_haz = ((fn == FN_MEM) & mem_blk)
                    | ((fn == FN_MD)  & md_blk)
                    | ((fn == FN_CSR) & ((|pend_vec) | mem_blk | md_blk));

  assign hazard = raw_haz | waw_haz | struct_haz;
  assign stall  = issue_valid & ~flush & hazard;
  assign fire   = issue_valid & ~flush & ~hazard;

  always_comb begin
    if (!stall)       stallnum = 2'b00;
    else if (raw_haz) stallnum = 2'b01;
    else if (waw_haz) stallnum = 2'b10;
    else              stallnum = 2'b11;
  end

  // Writeback clears first, then a firing writer sets, so set wins when
  // both target the same register in one cycle.
  always_comb begin
    pending_next = pending & ~wb_mask;
    if (fire && we && rd != 5'd0) pending_next[rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      mem_busy     <= 1'b0;
      md_busy      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      pending <= pending_next;

      if (fire && fn == FN_MEM) mem_busy <= 1'b1;
      else if (mem_done)        mem_busy <= 1'b0;

      if (fire && fn == FN_MD)  md_busy <= 1'b1;
      else if (md_done)         md_busy <= 1'b0;

      if (stall && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        use_rs1, use_rs2, we, flush, wb_valid, mem_done, md_done;
  logic [2:0]  fn;
  logic        stall, fire;
  logic [1:0]  stallnum;
  logic [31:0] pending;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  issue_scoreboard #(.NREGS(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .rd(rd), .we(we), .fn(fn), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .mem_done(mem_done), .md_done(md_done),
    .stall(stall), .stallnum(stallnum), .fire(fire),
    .pending(pending), .stall_cycles(stall_cycles)
  );

  // driver tasks
  task automatic idle();
    issue_valid = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0;
    rd = 0; we = 0; fn = 0; flush = 0; wb_valid = 0; wb_rd = 0;
    mem_done = 0; md_done = 0;
  endtask

  // advance one edge, then drive/check 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic w, input logic [4:0] d);
    idle();
    issue_valid = 1; fn = f; we = w; rd = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic s, input logic [1:0] sn, input logic f);
    chk({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, "_stallnum"}, {30'd0, stallnum}, {30'd0, sn});
    chk({tag, "_fire"}, {31'd0, fire}, {31'd0, f});
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    chk_out("reset", 0, 2'b00, 0);
    chk("reset_pending", pending, 32'h0);
    chk("reset_cnt", stall_cycles, 32'd0);

    // back-to-back RAW
    step();
    issue(3'd0, 1, 5'd5);
    #1 chk_out("raw_c0", 0, 2'b00, 1);
    step();
    chk("raw_pend5", pending, 32'h0000_0020);
    issue(3'd0, 0, 5'd0); use_rs1 = 1; rs1 = 5'd5;
    #1 chk_out("raw_c1", 1, 2'b01, 0);
    step();
    wb_valid = 1; wb_rd = 5'd5;
    #1 chk_out("raw_c2", 0, 2'b00, 1);
    step();
    chk("raw_pend_clr", pending, 32'h0);
    chk("raw_cnt", stall_cycles, 32'd1);

    // x0 destination
    issue(3'd0, 1, 5'd0);
    #1 chk_out("x0_issue", 0, 2'b00, 1);
    step();
    chk("x0_pend", pending, 32'h0);
    issue(3'd0, 0, 5'd0); use_rs1 = 1; rs1 = 5'd0;
    #1 chk_out("x0_read", 0, 2'b00, 1);
    step();

    // structural on muldiv
    issue(3'd3, 0, 5'd0);
    #1 chk_out("md_first", 0, 2'b00, 1);
    step();
    issue(3'd3, 0, 5'd0);
    #1 chk_out("md_busy", 1, 2'b11, 0);
    issue(3'd7, 0, 5'd0);
    #1 chk_out("fn7_alu", 0, 2'b00, 1);
    issue(3'd3, 0, 5'd0); md_done = 1;
    #1 chk_out("md_done_same", 0, 2'b00, 1);
    step();
    issue(3'd3, 0, 5'd0);
    #1 chk_out("md_still_busy", 1, 2'b11, 0);
    idle(); md_done = 1;
    step();
    idle();
    issue(3'd3, 0, 5'd0);
    #1 chk_out("md_freed", 0, 2'b00, 1);
    step();
    idle(); md_done = 1;
    step();

    // structural on mem, stray done ignored
    idle(); mem_done = 1;
    step();
    issue(3'd2, 0, 5'd0);
    #1 chk_out("mem_first", 0, 2'b00, 1);
    step();
    issue(3'd2, 0, 5'd0);
    #1 chk_out("mem_busy", 1, 2'b11, 0);
    idle(); mem_done = 1;
    step();
    issue(3'd2, 0, 5'd0);
    #1 chk_out("mem_freed", 0, 2'b00, 1);
    step();
    idle(); mem_done = 1;
    step();

    // WAW plus writeback collision
    issue(3'd0, 1, 5'd7);
    step();
    chk("waw_pend7", pending, 32'h0000_0080);
    issue(3'd0, 1, 5'd7);
    #1 chk_out("waw", 1, 2'b10, 0);
    use_rs1 = 1; rs1 = 5'd7;
    #1 chk_out("raw_over_waw", 1, 2'b01, 0);
    use_rs1 = 0; wb_valid = 1; wb_rd = 5'd7;
    #1 chk_out("waw_wb", 0, 2'b00, 1);
    step();
    chk("waw_setwins", pending, 32'h0000_0080);
    idle(); wb_valid = 1; wb_rd = 5'd7;
    step();
    chk("waw_clr", pending, 32'h0);

    // CSR serialize and flush
    issue(3'd0, 1, 5'd3);
    step();
    issue(3'd4, 0, 5'd0);
    #1 chk_out("csr_stall", 1, 2'b11, 0);
    flush = 1;
    #1 chk_out("csr_flush", 0, 2'b00, 0);
    step();
    chk("csr_flush_pend", pending, 32'h0000_0008);
    issue(3'd4, 0, 5'd0); wb_valid = 1; wb_rd = 5'd3;
    #1 chk_out("csr_after_wb", 0, 2'b00, 1);
    step();
    chk("csr_pend_clr", pending, 32'h0);

    // fresh reset, then counter and asynchronous reset
    idle(); rst = 1;
    #1 rst = 0;
    step();
    chk("rst2_cnt", stall_cycles, 32'd0);
    issue(3'd3, 1, 5'd9);
    #1 chk_out("cnt_issue", 0, 2'b00, 1);
    step();
    issue(3'd0, 0, 5'd0); use_rs1 = 1; rs1 = 5'd9;
    step(); step(); step(); step();
    chk("cnt_four", stall_cycles, 32'd4);
    chk("cnt_pend9", pending, 32'h0000_0200);
    #2 rst = 1;
    #1;
    chk("arst_pend", pending, 32'h0);
    chk("arst_cnt", stall_cycles, 32'd0);
    chk_out("arst_raw_gone", 0, 2'b00, 1);
    issue(3'd3, 0, 5'd0);
    #1 chk_out("arst_md_free", 0, 2'b00, 1);
    idle();
    step();
    rst = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
